ram_burst_sp: RTL and testbench

Parametrised single-port synchronous RAM with a built-in burst engine, occupancy tracking and optional parity. Successor to the fixed 8×32 single-port RAM: same single-access write/read behaviour, generalised in width and depth, plus auto-incrementing read/write bursts with wrap-around and a per-location written-flag that drives `full` and `used`. Sits between a host/controller FSM and any buffer consumer in the datapath.

---
 rtl/ram_pkg.sv | 11 +
 rtl/ram_sp_core.sv | 24 ++
 rtl/ram_burst_sp.sv | 152 +++++++++++++++
 tb/tb_ram_burst_sp.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared FSM encoding and burst-direction constants for ram_burst_sp.
package ram_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_DONE} state_e;

  localparam logic MODE_RD = 1'b0;
  localparam logic MODE_WR = 1'b1;

  function automatic logic even_par(input logic [63:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/ram_sp_core.sv
// Plain single-port storage: synchronous write, registered read that holds between reads.
module ram_sp_core #(
  parameter int W  = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rdata_q, rdata_d;

  always_comb rdata_d = re ? mem[addr] : rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/ram_burst_sp.sv
// Single-port RAM with read/write burst engine, written-flag occupancy tracking,
// and optional even parity per word when RAM_PARITY_EN is defined.
module ram_burst_sp
  import ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              re,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] q,
  output logic              valid,
  output logic              full,
  output logic [ADDR_W:0]   used,
  output logic              parity_err
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
`ifdef RAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              mode_q, mode_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic              hit_q, hit_d;
  logic [DEPTH-1:0]  flag_q, flag_d;
  logic [ADDR_W:0]   used_q, used_d;

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata, mem_rdata;

`ifdef RAM_PARITY_EN
  assign mem_wdata = {even_par(64'(data)), data};
`else
  assign mem_wdata = data;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    hit_d    = hit_q;
    flag_d   = flag_q;
    used_d   = used_q;
    valid_d  = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = addr;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d   = addr;
          mode_d  = mode;
          rem_d   = (len == '0) ? DEPTH_C : {1'b0, len};
          state_d = ST_BURST;
        end else if (we) begin
          mem_we = 1'b1;
        end else if (re) begin
          mem_re = 1'b1;
        end
      end
      ST_BURST: begin
        mem_addr = ptr_q;
        // Reads issue every cycle; writes only advance on a qualified beat.
        if (mode_q == MODE_RD || we) begin
          mem_re = (mode_q == MODE_RD);
          mem_we = (mode_q == MODE_WR);
          ptr_d  = ptr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == 1) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (mem_re) begin
      valid_d = 1'b1;
      hit_d   = flag_q[mem_addr];
    end
    if (mem_we) begin
      flag_d[mem_addr] = 1'b1;
      if (!flag_q[mem_addr]) used_d = used_q + 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      mode_q  <= MODE_RD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
      flag_q  <= '0;
      used_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      hit_q   <= hit_d;
      flag_q  <= flag_d;
      used_q  <= used_d;
    end
  end

  ram_sp_core #(.W(WORD_W), .AW(ADDR_W)) u_core (
    .clk   (clk),
    .we    (mem_we & ~rst),
    .re    (mem_re & ~rst),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Never-written locations read as zero regardless of stale array contents.
  assign q     = hit_q ? mem_rdata[DATA_W-1:0] : '0;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign used  = used_q;
  assign full  = (used_q == DEPTH_C);
`ifdef RAM_PARITY_EN
  assign parity_err = valid_q & hit_q & (^mem_rdata);
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_ram_burst_sp.sv
// Directed bench for ram_burst_sp: single access, write/read bursts, stall, wrap, full, reset.
module tb_ram_burst_sp;
  logic       clk = 1'b0;
  logic       rst, we, re, start, mode;
  logic [7:0] data;
  logic [4:0] addr, len;
  logic       busy, done, valid, full, parity_err;
  logic [7:0] q;
  logic [5:0] used;
  int total = 0, bad = 0;

  ram_burst_sp #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .data(data), .addr(addr), .we(we), .re(re),
    .start(start), .mode(mode), .len(len), .busy(busy), .done(done),
    .q(q), .valid(valid), .full(full), .used(used), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [7:0] exp, input string tag);
    re = 1'b1; addr = a;
    step();
    re = 1'b0;
    chk({tag, "_q"}, q, exp);
    chk({tag, "_v"}, valid, 1);
    chk({tag, "_perr"}, parity_err, 0);
  endtask

  initial begin
    rst = 1'b1; we = 0; re = 0; start = 0; mode = 0; data = 0; addr = 0; len = 0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", valid, 0);
    chk("rst_q", q, 0);
    chk("rst_full", full, 0);
    chk("rst_used", used, 0);
    chk("rst_perr", parity_err, 0);

    // single write then reads
    we = 1; addr = 5'd3; data = 8'hA5;
    step();
    we = 0;
    chk("sw_used", used, 1);
    chk("sw_valid", valid, 0);
    rd_chk(5'd3, 8'hA5, "sr3");
    step();
    chk("hold_valid", valid, 0);
    chk("hold_q", q, 8'hA5);
    rd_chk(5'd4, 8'h00, "sr4_unwritten");

    // write burst with wrap: 30,31,0,1
    start = 1; mode = 1; addr = 5'd30; len = 5'd4;
    step();
    start = 0;
    chk("wb_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      we = 1; data = 8'h11 * (i + 1);
      step();
      chk($sformatf("wb_done%0d", i), done, (i == 3));
    end
    we = 0;
    chk("wb_used", used, 5);
    step();
    chk("wb_idle_busy", busy, 0);
    rd_chk(5'd30, 8'h11, "wb30");
    rd_chk(5'd31, 8'h22, "wb31");
    rd_chk(5'd0, 8'h33, "wb0");
    rd_chk(5'd1, 8'h44, "wb1");

    // stalled write burst: beats only on we=1
    start = 1; mode = 1; addr = 5'd10; len = 5'd3;
    step();
    start = 0;
    for (int i = 0; i < 5; i++) begin
      we = (i % 2 == 0); data = 8'hA0 + 8'(i);
      step();
      chk($sformatf("st_busy%0d", i), busy, 1);
      chk($sformatf("st_done%0d", i), done, (i == 4));
    end
    we = 0;
    step();
    chk("st_used", used, 8);
    chk("st_full", full, 0);
    rd_chk(5'd10, 8'hA0, "st10");
    rd_chk(5'd11, 8'hA2, "st11");
    rd_chk(5'd12, 8'hA4, "st12");
    rd_chk(5'd13, 8'h00, "st13");

    // len=0 -> full-depth burst
    start = 1; mode = 1; addr = 5'd0; len = 5'd0;
    step();
    start = 0;
    for (int i = 0; i < 32; i++) begin
      we = 1; data = 8'h80 + 8'(i);
      step();
    end
    we = 0;
    chk("fb_done", done, 1);
    chk("fb_used", used, 32);
    chk("fb_full", full, 1);
    step();
    we = 1; addr = 5'd5; data = 8'h55;
    step();
    we = 0;
    step();
    chk("rw_used", used, 32);
    chk("rw_full", full, 1);
    rd_chk(5'd5, 8'h55, "rw5");

    // read burst with wrap; start/we during burst must be ignored
    start = 1; mode = 0; addr = 5'd30; len = 5'd4;
    step();
    chk("rb_busy", busy, 1);
    chk("rb_v0", valid, 0);
    start = 1; mode = 1; we = 1; addr = 5'd7; data = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rb_valid%0d", i), valid, 1);
      chk($sformatf("rb_q%0d", i), q, 8'h80 + 8'((30 + i) % 32));
      chk($sformatf("rb_done%0d", i), done, (i == 3));
    end
    start = 0; we = 0;
    step();
    chk("rb_end_busy", busy, 0);
    chk("rb_end_valid", valid, 0);
    chk("rb_used", used, 32);
    rd_chk(5'd7, 8'h87, "rb_no_we");

    // reset in the middle of a write burst
    start = 1; mode = 1; addr = 5'd20; len = 5'd8;
    step();
    start = 0;
    we = 1; data = 8'hC1; step();
    data = 8'hC2; step();
    rst = 1;
    step();
    rst = 0; we = 0;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_used", used, 0);
    chk("mr_full", full, 0);
    rd_chk(5'd20, 8'h00, "mr20");
    step();
    chk("mr_busy2", busy, 0);

`ifdef RAM_PARITY_EN
    we = 1; addr = 5'd2; data = 8'h0F;
    step();
    we = 0;
    dut.u_core.mem[2] = dut.u_core.mem[2] ^ 9'h001;
    re = 1; addr = 5'd2;
    step();
    re = 0;
    chk("par_err", parity_err, 1);
    step();
    chk("par_err_pulse", parity_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
